// File: rtl/operand_issue_stage_if.sv
// operand_issue_stage_if: decode/register-file/bypass/execute signals of the operand issue stage.
// master drives decode, register file data, bypasses, long-latency writeback and out_ready.
// slave is the stage: it drives in_ready, grf_addr1/2 and the out_* register.
interface operand_issue_stage_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic        in_use_rs;
    logic        in_use_rt;
    logic [4:0]  in_dest;
    logic        in_long;
    logic [4:0]  grf_addr1;
    logic [4:0]  grf_addr2;
    logic [31:0] grf_data1;
    logic [31:0] grf_data2;
    logic        ex_fwd_valid;
    logic [4:0]  ex_fwd_addr;
    logic [31:0] ex_fwd_data;
    logic        mem_fwd_valid;
    logic [4:0]  mem_fwd_addr;
    logic [31:0] mem_fwd_data;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        lr_done;
    logic [4:0]  lr_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_rs_val;
    logic [31:0] out_rt_val;
    logic [4:0]  out_dest;
    logic        out_long;

    modport master (
        output flush, in_valid, in_pc, in_rs, in_rt, in_use_rs, in_use_rt, in_dest, in_long,
               grf_data1, grf_data2, ex_fwd_valid, ex_fwd_addr, ex_fwd_data,
               mem_fwd_valid, mem_fwd_addr, mem_fwd_data, wb_addr, wb_data,
               lr_done, lr_addr, out_ready,
        input  in_ready, grf_addr1, grf_addr2, out_valid, out_pc, out_rs_val, out_rt_val,
               out_dest, out_long
    );

    modport slave (
        input  flush, in_valid, in_pc, in_rs, in_rt, in_use_rs, in_use_rt, in_dest, in_long,
               grf_data1, grf_data2, ex_fwd_valid, ex_fwd_addr, ex_fwd_data,
               mem_fwd_valid, mem_fwd_addr, mem_fwd_data, wb_addr, wb_data,
               lr_done, lr_addr, out_ready,
        output in_ready, grf_addr1, grf_addr2, out_valid, out_pc, out_rs_val, out_rt_val,
               out_dest, out_long
    );
endinterface

// File: rtl/operand_issue_stage.sv
// operand_issue_stage: reads/bypasses source operands, stalls on RAW hazards, issues to execute.
// Ports: clk, reset (sync, active-high), bus (operand_issue_stage_if.slave: decode in_*,
// register file grf_*, ex/mem/wb bypasses, lr_* long-latency completion, execute out_*).
module operand_issue_stage (
    input logic            clk,
    input logic            reset,
    operand_issue_stage_if.slave bus
);
    logic [31:0] pending, pending_nxt;
    logic        out_valid, out_long;
    logic [31:0] out_pc, out_rs_val, out_rt_val;
    logic [4:0]  out_dest;
    logic [31:0] rs_val, rt_val;
    logic        haz_rs, haz_rt, accept;

    assign bus.grf_addr1 = bus.in_rs;
    assign bus.grf_addr2 = bus.in_rt;

    // Youngest producer wins; the wb match needs no nonzero test because r0 is caught first.
    assign rs_val = (bus.in_rs == 5'd0) ? 32'd0 :
                    (bus.ex_fwd_valid && bus.ex_fwd_addr == bus.in_rs) ? bus.ex_fwd_data :
                    (bus.mem_fwd_valid && bus.mem_fwd_addr == bus.in_rs) ? bus.mem_fwd_data :
                    (bus.wb_addr == bus.in_rs) ? bus.wb_data : bus.grf_data1;
    assign rt_val = (bus.in_rt == 5'd0) ? 32'd0 :
                    (bus.ex_fwd_valid && bus.ex_fwd_addr == bus.in_rt) ? bus.ex_fwd_data :
                    (bus.mem_fwd_valid && bus.mem_fwd_addr == bus.in_rt) ? bus.mem_fwd_data :
                    (bus.wb_addr == bus.in_rt) ? bus.wb_data : bus.grf_data2;

    // A same-cycle lr_done for the register releases the stall; its data rides the wb bypass.
    assign haz_rs = bus.in_use_rs && bus.in_rs != 5'd0 &&
                    ((out_valid && out_dest == bus.in_rs) ||
                     (pending[bus.in_rs] && !(bus.lr_done && bus.lr_addr == bus.in_rs)));
    assign haz_rt = bus.in_use_rt && bus.in_rt != 5'd0 &&
                    ((out_valid && out_dest == bus.in_rt) ||
                     (pending[bus.in_rt] && !(bus.lr_done && bus.lr_addr == bus.in_rt)));

    assign bus.in_ready = !bus.flush && !haz_rs && !haz_rt && (!out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // Set is applied after clear so a dispatch colliding with completion keeps the bit.
    always_comb begin
        pending_nxt = pending;
        if (bus.lr_done) pending_nxt[bus.lr_addr] = 1'b0;
        if (out_valid && bus.out_ready && out_long) pending_nxt[out_dest] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending    <= '0;
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_rs_val <= '0;
            out_rt_val <= '0;
            out_dest   <= '0;
            out_long   <= 1'b0;
        end else begin
            pending <= pending_nxt;
            if (bus.flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid  <= 1'b1;
                out_pc     <= bus.in_pc;
                out_rs_val <= rs_val;
                out_rt_val <= rt_val;
                out_dest   <= bus.in_dest;
                out_long   <= bus.in_long;
            end else if (bus.out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid  = out_valid;
    assign bus.out_pc     = out_pc;
    assign bus.out_rs_val = out_rs_val;
    assign bus.out_rt_val = out_rt_val;
    assign bus.out_dest   = out_dest;
    assign bus.out_long   = out_long;
endmodule

// File: tb/tb_operand_issue_stage.sv
// tb_operand_issue_stage: directed and randomized checks of operand_issue_stage against a reference model.
module tb_operand_issue_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    operand_issue_stage_if bus();
    operand_issue_stage dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int n_checks = 0;
    int n_pass   = 0;

    bit          m_valid, m_long;
    logic [31:0] m_pc, m_rs, m_rt;
    logic [4:0]  m_dest;
    bit          m_pend [32];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] g);
        if (r == 5'd0) return 32'd0;
        if (bus.ex_fwd_valid && bus.ex_fwd_addr == r) return bus.ex_fwd_data;
        if (bus.mem_fwd_valid && bus.mem_fwd_addr == r) return bus.mem_fwd_data;
        if (bus.wb_addr == r) return bus.wb_data;
        return g;
    endfunction

    function automatic bit blocked(input bit used, input logic [4:0] r);
        if (!used || r == 5'd0) return 1'b0;
        if (m_valid && m_dest == r) return 1'b1;
        return m_pend[r] && !(bus.lr_done && bus.lr_addr == r);
    endfunction

    function automatic bit model_ready();
        return !bus.flush && !blocked(bus.in_use_rs, bus.in_rs) &&
               !blocked(bus.in_use_rt, bus.in_rt) && (!m_valid || bus.out_ready);
    endfunction

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic cyc();
        bit rdy;
        #3;
        rdy = model_ready();
        check("in_ready", 32'(bus.in_ready), 32'(rdy));
        check("grf_addr1", 32'(bus.grf_addr1), 32'(bus.in_rs));
        check("grf_addr2", 32'(bus.grf_addr2), 32'(bus.in_rt));
        if (reset) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_valid = 1'b0; m_pc = 32'd0; m_rs = 32'd0; m_rt = 32'd0; m_dest = 5'd0; m_long = 1'b0;
        end else begin
            if (bus.lr_done) m_pend[bus.lr_addr] = 1'b0;
            if (m_valid && bus.out_ready && m_long && m_dest != 5'd0) m_pend[m_dest] = 1'b1;
            if (bus.flush) m_valid = 1'b0;
            else if (bus.in_valid && rdy) begin
                m_valid = 1'b1;
                m_pc    = bus.in_pc;
                m_rs    = operand(bus.in_rs, bus.grf_data1);
                m_rt    = operand(bus.in_rt, bus.grf_data2);
                m_dest  = bus.in_dest;
                m_long  = bus.in_long;
            end else if (bus.out_ready) m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check("out_valid", 32'(bus.out_valid), 32'(m_valid));
        check("out_pc", bus.out_pc, m_pc);
        check("out_rs_val", bus.out_rs_val, m_rs);
        check("out_rt_val", bus.out_rt_val, m_rt);
        check("out_dest", 32'(bus.out_dest), 32'(m_dest));
        check("out_long", 32'(bus.out_long), 32'(m_long));
    endtask

    task automatic expect_ready(input bit v, input string tag);
        #2;
        check(tag, 32'(bus.in_ready), 32'(v));
    endtask

    task automatic idle();
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_pc = 32'd0;
        bus.in_rs = 5'd0; bus.in_rt = 5'd0; bus.in_use_rs = 1'b0; bus.in_use_rt = 1'b0;
        bus.in_dest = 5'd0; bus.in_long = 1'b0;
        bus.grf_data1 = $urandom; bus.grf_data2 = $urandom;
        bus.ex_fwd_valid = 1'b0; bus.ex_fwd_addr = 5'd0; bus.ex_fwd_data = $urandom;
        bus.mem_fwd_valid = 1'b0; bus.mem_fwd_addr = 5'd0; bus.mem_fwd_data = $urandom;
        bus.wb_addr = 5'd0; bus.wb_data = $urandom;
        bus.lr_done = 1'b0; bus.lr_addr = 5'd0; bus.out_ready = 1'b1;
    endtask

    task automatic instr(input logic [31:0] pc, input logic [4:0] rs, input bit urs,
                         input logic [4:0] rt, input bit urt, input logic [4:0] dest, input bit lng);
        bus.in_valid = 1'b1; bus.in_pc = pc; bus.in_rs = rs; bus.in_use_rs = urs;
        bus.in_rt = rt; bus.in_use_rt = urt; bus.in_dest = dest; bus.in_long = lng;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        // Reset with a valid instruction waiting: nothing loads until the first edge after deassert.
        instr(32'h100, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0);
        cyc();
        check("reset_hold0", 32'(bus.out_valid), 32'd0);
        cyc();
        check("reset_hold1", 32'(bus.out_valid), 32'd0);
        reset = 1'b0;
        cyc();
        check("first_accept", 32'(bus.out_valid), 32'd1);
        check("first_pc", bus.out_pc, 32'h100);

        // Bypass priority on rs=5.
        idle();
        instr(32'h104, 5'd5, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0);
        bus.ex_fwd_valid = 1'b1;  bus.ex_fwd_addr = 5'd5;  bus.ex_fwd_data = 32'hAAAA0001;
        bus.mem_fwd_valid = 1'b1; bus.mem_fwd_addr = 5'd5; bus.mem_fwd_data = 32'hBBBB0002;
        bus.wb_addr = 5'd5; bus.wb_data = 32'hCCCC0003;
        bus.grf_data1 = 32'hDDDD0004; bus.grf_data2 = 32'h00000066;
        cyc();
        check("fwd_ex", bus.out_rs_val, 32'hAAAA0001);
        check("fwd_grf_rt", bus.out_rt_val, 32'h00000066);
        bus.ex_fwd_valid = 1'b0; bus.in_pc = 32'h108;
        cyc();
        check("fwd_mem", bus.out_rs_val, 32'hBBBB0002);
        bus.mem_fwd_valid = 1'b0; bus.in_pc = 32'h10C;
        cyc();
        check("fwd_wb", bus.out_rs_val, 32'hCCCC0003);
        bus.ex_fwd_valid = 1'b1; bus.mem_fwd_valid = 1'b1;
        bus.ex_fwd_addr = 5'd0; bus.mem_fwd_addr = 5'd0; bus.wb_addr = 5'd0;
        bus.in_rs = 5'd0; bus.in_pc = 32'h110;
        cyc();
        check("fwd_r0", bus.out_rs_val, 32'd0);

        // Back-to-back dependent short ops: one bubble, then ex bypass.
        idle();
        instr(32'h200, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b0);
        cyc();
        instr(32'h204, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        expect_ready(1'b0, "raw_stall");
        cyc();
        check("raw_bubble", 32'(bus.out_valid), 32'd0);
        bus.ex_fwd_valid = 1'b1; bus.ex_fwd_addr = 5'd8; bus.ex_fwd_data = 32'h0808F00D;
        cyc();
        check("raw_issue_pc", bus.out_pc, 32'h204);
        check("raw_ex_data", bus.out_rs_val, 32'h0808F00D);

        // Load-use: four stall cycles, released by lr_done with the wb bypass.
        idle();
        instr(32'h300, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
        cyc();
        instr(32'h304, 5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            expect_ready(1'b0, "load_use_stall");
            cyc();
        end
        bus.lr_done = 1'b1; bus.lr_addr = 5'd9; bus.wb_addr = 5'd9; bus.wb_data = 32'h12345678;
        bus.grf_data2 = 32'hDEADBEEF;
        expect_ready(1'b1, "load_use_release");
        cyc();
        check("load_use_pc", bus.out_pc, 32'h304);
        check("load_use_data", bus.out_rt_val, 32'h12345678);
        idle();
        instr(32'h308, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        expect_ready(1'b1, "pend9_cleared");
        cyc();

        // Set/clear collision on register 3.
        idle();
        instr(32'h400, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        cyc();
        idle();
        cyc();
        instr(32'h404, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        cyc();
        idle();
        bus.lr_done = 1'b1; bus.lr_addr = 5'd3; bus.wb_addr = 5'd3;
        cyc();
        idle();
        instr(32'h408, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        expect_ready(1'b0, "collision_set_wins");
        cyc();

        // Flush with backpressure; pending[3] survives it.
        idle();
        instr(32'h500, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        bus.out_ready = 1'b0;
        cyc();
        instr(32'h504, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        bus.flush = 1'b1;
        expect_ready(1'b0, "flush_blocks");
        cyc();
        check("flush_kills", 32'(bus.out_valid), 32'd0);
        idle();
        instr(32'h508, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        expect_ready(1'b0, "flush_keeps_pend");
        cyc();

        // Backpressure: fields hold for three cycles.
        idle();
        instr(32'h600, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b0);
        bus.out_ready = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            idle();
            instr(32'h700 + 32'(i), 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b0);
            bus.out_ready = 1'b0;
            cyc();
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_pc", bus.out_pc, 32'h600);
            check("bp_dest", 32'(bus.out_dest), 32'd4);
        end
        idle();
        bus.lr_done = 1'b1; bus.lr_addr = 5'd3;
        cyc();

        // Randomized traffic over a small register set to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            idle();
            bus.in_valid  = ($urandom_range(3) != 0);
            bus.in_pc     = $urandom;
            bus.in_rs     = 5'($urandom_range(7));
            bus.in_rt     = 5'($urandom_range(7));
            bus.in_use_rs = 1'($urandom_range(1));
            bus.in_use_rt = 1'($urandom_range(1));
            bus.in_dest   = 5'($urandom_range(7));
            bus.in_long   = ($urandom_range(3) == 0);
            bus.ex_fwd_valid  = 1'($urandom_range(1));
            bus.ex_fwd_addr   = 5'($urandom_range(7));
            bus.mem_fwd_valid = 1'($urandom_range(1));
            bus.mem_fwd_addr  = 5'($urandom_range(7));
            bus.lr_done   = ($urandom_range(3) == 0);
            bus.lr_addr   = 5'($urandom_range(7));
            bus.wb_addr   = bus.lr_done ? bus.lr_addr : 5'($urandom_range(7));
            bus.out_ready = ($urandom_range(3) != 0);
            bus.flush     = ($urandom_range(19) == 0);
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/operand_issue_stage.md
# operand_issue_stage

Pipeline stage between decode and execute in the MIPS core. It drives the general register file's two combinational read ports and merges their data with EX/MEM/WB forwarding. It stalls on RAW hazards, using a 32-entry scoreboard for long-latency producers (loads, mul/div). It hands fully resolved operands to execute through a single valid/ready output register.

## Interface
Parameters: none; widths are fixed by the 32×32 register file.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high; one clock, all state sampled on rising edge
- flush  in  1  kill the output register and block acceptance this cycle
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_pc  in  32  instruction PC
- in_rs, in_rt  in  5  source register numbers
- in_use_rs, in_use_rt  in  1  source actually read
- in_dest  in  5  destination register (0 = none)
- in_long  in  1  result arrives late via the lr_* port
- grf_addr1, grf_addr2  out  5  register file read addresses (= in_rs, in_rt, combinational)
- grf_data1, grf_data2  in  32  register file read data (combinational)
- ex_fwd_valid  in  1; ex_fwd_addr  in  5; ex_fwd_data  in  32  EX result bypass
- mem_fwd_valid  in  1; mem_fwd_addr  in  5; mem_fwd_data  in  32  MEM result bypass
- wb_addr  in  5; wb_data  in  32  register file write port (same value the register file latches at this edge)
- lr_done  in  1; lr_addr  in  5  long-latency result written back this cycle; data also appears on wb_*
- out_valid  out  1; out_ready  in  1  handshake to execute
- out_pc  out  32; out_rs_val, out_rt_val  out  32; out_dest  out  5; out_long  out  1

## Operation
- Operand select per source, priority high→low:
  - register 0 → 0
  - ex_fwd (valid, addr match)
  - mem_fwd (valid, addr match)
  - wb (wb_addr match, wb_addr≠0)
  - grf_data
- Scoreboard pending[31:0], bit 0 hard-wired 0.
  - Set: pending[out_dest] when out_valid && out_ready && out_long && out_dest≠0.
  - Clear: pending[lr_addr] when lr_done.
  - Set and clear of the same bit in the same cycle: set wins.
- Hazard for a used source s≠0, either condition stalls:
  - (a) out_valid && out_dest==s. Applies to any producer; its result is not yet visible.
  - (b) pending[s] && !(lr_done && lr_addr==s). A same-cycle lr_done releases the stall; data comes from the wb bypass.
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- Output register:
  - Load on in_valid && in_ready.
  - Else clear out_valid on out_ready or flush.
  - Else hold all fields unchanged.
- flush:
  - Clears out_valid next edge.
  - Does not touch pending; dispatched long ops still complete via lr_done.
  - Flush has priority over load.

## Timing
- Reset values: out_valid=0, out_pc=0, out_rs_val=0, out_rt_val=0, out_dest=0, out_long=0, pending=0.
- in_ready is combinational; it can be 1 during reset only if no hazard exists, but nothing loads while reset is asserted.
- Latency: accept at edge N → out_valid=1 after edge N. Throughput is 1/cycle when no hazard and out_ready=1.
- Back-to-back dependent short ops: exactly 1 bubble. The second instruction waits until the producer leaves the output register, then gets its data from ex_fwd.
- Long producer: consumer stalls from the cycle the producer dispatches until the cycle lr_done matches, inclusive of release in that cycle.
- out_* fields are stable while out_valid && !out_ready.

## Test plan
- Reset: assert reset for 2 cycles with in_valid=1 → out_valid=0, pending=0, nothing loads; first accept occurs on the first edge after deassert.
- Forward priority: rs=5 with ex_fwd(5,0xAAAA0001), mem_fwd(5,0xBBBB0002), wb(5,0xCCCC0003), grf 0xDDDD0004 → out_rs_val=0xAAAA0001. Drop ex → 0xBBBB0002; drop ex and mem → 0xCCCC0003. rs=0 with all bypasses addressed to 0 → 0.
- Short RAW: A(dest=8) then B(rs=8) → B held one cycle (in_ready=0); B issues with out_rs_val=ex_fwd_data for addr 8.
- Load-use: long A(dest=9) dispatches; B(rt=9) stalls 4 cycles; lr_done(9) with wb(9,0x12345678) in cycle 5 → B accepted that cycle, out_rt_val=0x12345678, pending[9]=0.
- Set/clear collision: pending[3]=1; new long C(dest=3) dispatches in the same cycle as lr_done(3) → pending[3] remains 1.
- Flush: out_valid=1, out_ready=0, flush=1 with in_valid=1 → next cycle out_valid=0, nothing accepted, pending bits unchanged; backpressure check: out_ready=0 for 3 cycles → out_* fields constant.
